// File: rtl/nn_layer_sequencer_if.sv
// rtl/nn_layer_sequencer_if.sv - sample, weight-bank and result signals of the layer sequencer
interface nn_layer_sequencer_if #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 4,
    parameter int WW    = 10,
    parameter int AW    = 7
);
    logic [N_IN-1:0]     in_data;
    logic                in_valid;
    logic                in_ready;
    logic [AW-1:0]       wb_addr;
    logic                wb_rd_en;
    logic [WW-1:0]       wb_data;
    logic [N_OUT-1:0]    out_d;
    logic [N_OUT*15-1:0] out_sum;
    logic                out_valid;
    logic                out_ready;

    // Producer / consumer / weight-memory side
    modport master (
        output in_data, in_valid, wb_data, out_ready,
        input  in_ready, wb_addr, wb_rd_en, out_d, out_sum, out_valid
    );

    // Sequencer side
    modport slave (
        input  in_data, in_valid, wb_data, out_ready,
        output in_ready, wb_addr, wb_rd_en, out_d, out_sum, out_valid
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - binary-input neuron layer: weight-bank walk, masked accumulate, sign decision
module nn_layer_sequencer #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 4,
    parameter int WW    = 10,
    parameter int AW    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    nn_layer_sequencer_if.slave  bus
);
    localparam int SW    = 15;
    localparam int TOTAL = N_OUT * (N_IN + 1);
    localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [AW-1:0] K_BIAS    = AW'(N_IN);
    localparam logic [AW-1:0] CNT_LAST  = AW'(TOTAL - 1);
    localparam logic [AW-1:0] BIAS_BASE = AW'(N_OUT * N_IN);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           cnt_q, k_q, j_q;
    logic [AW-1:0]           kp_q, jp_q;
    logic                    vld_q;
    logic [N_IN-1:0]         din_q;
    logic [N_IN-1:0]         din_rev;
    logic signed [SW-1:0]    acc_q, acc_d, wext, term;
    logic [N_OUT-1:0]        out_d_q;
    logic [N_OUT*SW-1:0]     out_sum_q;
    logic                    accept;

    assign accept      = (state_q == IDLE) && bus.in_valid;
    assign bus.out_d   = out_d_q;
    assign bus.out_sum = out_sum_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state plus handshake and weight-bank strobes decoded from state
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.wb_rd_en  = 1'b0;
        bus.wb_addr   = '0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                bus.wb_rd_en = 1'b1;
                // Per neuron: its N_IN weights, then its bias from the tail of the bank
                bus.wb_addr  = (k_q == K_BIAS) ? BIAS_BASE + j_q : AW'(j_q * N_IN) + k_q;
                if (cnt_q == CNT_LAST) state_d = DRAIN;
            end
            DRAIN: state_d = HOLD;
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address walk: cnt is the linear step, k/j the weight and neuron position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            k_q   <= '0;
            j_q   <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            k_q   <= '0;
            j_q   <= '0;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
            if (k_q == K_BIAS) begin
                k_q <= '0;
                j_q <= j_q + 1'b1;
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    // Weight k pairs with input bit N_IN-1-k; restart the sum on each neuron's first weight
    always_comb begin
        for (int i = 0; i < N_IN; i++) din_rev[i] = din_q[N_IN-1-i];
        wext  = {{(SW-WW){bus.wb_data[WW-1]}}, bus.wb_data};
        term  = ((kp_q == K_BIAS) || din_rev[kp_q[KW-1:0]]) ? wext : '0;
        acc_d = (kp_q == '0) ? term : acc_q + term;
    end

    // Read-data pipeline: position of last cycle's address travels with the returning data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q     <= 1'b0;
            kp_q      <= '0;
            jp_q      <= '0;
            din_q     <= '0;
            acc_q     <= '0;
            out_d_q   <= '0;
            out_sum_q <= '0;
        end else begin
            vld_q <= (state_q == RUN);
            kp_q  <= k_q;
            jp_q  <= j_q;
            if (accept) din_q <= bus.in_data;
            if (vld_q) begin
                acc_q <= acc_d;
                if (kp_q == K_BIAS) begin
                    for (int n = 0; n < N_OUT; n++) begin
                        if (jp_q == AW'(n)) begin
                            out_sum_q[(N_OUT-1-n)*SW +: SW] <= acc_d;
                            out_d_q[N_OUT-1-n]              <= ~acc_d[SW-1];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - scoreboard bench for nn_layer_sequencer
module tb_nn_layer_sequencer;
    localparam int N_IN  = 16;
    localparam int N_OUT = 4;
    localparam int WW    = 10;
    localparam int AW    = 7;
    localparam int LAT   = 69;

    typedef struct {
        logic [N_OUT-1:0]    d;
        logic [N_OUT*15-1:0] sum;
        int                  acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nn_layer_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .WW(WW), .AW(AW)) bus();

    nn_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .WW(WW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [WW-1:0] mem [0:(1<<AW)-1];
    exp_t          exp_q[$];
    logic [AW-1:0] trace[$];
    int            cyc   = 0;
    int            n_vec = 0;
    int            n_err = 0;
    bit            seen  = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk) if (bus.wb_rd_en) bus.wb_data <= mem[bus.wb_addr];

    always @(negedge clk) if (!reset && bus.wb_rd_en) trace.push_back(bus.wb_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [N_IN-1:0] d, input int acc);
        exp_t r;
        r.d   = '0;
        r.sum = '0;
        r.acc = acc;
        for (int j = 0; j < N_OUT; j++) begin
            int s;
            s = $signed(mem[N_OUT*N_IN + j]);
            for (int k = 0; k < N_IN; k++)
                if (d[N_IN-1-k]) s += $signed(mem[j*N_IN + k]);
            r.sum[(N_OUT-1-j)*15 +: 15] = 15'(s);
            r.d[N_OUT-1-j]              = (s >= 0);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else if (bus.out_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_d", 64'(bus.out_d), 64'(e.d));
                chk("out_sum", 64'(bus.out_sum), 64'(e.sum));
                chk("latency", 64'(cyc - e.acc), 64'(LAT));
            end
        end else if (!bus.out_valid) begin
            seen = 1'b0;
        end
    end

    task automatic accept_sample(input logic [N_IN-1:0] d);
        int t = 0;
        while (!bus.in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready_timeout", 64'(t >= 200), 64'd0);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(model(d, cyc));
        trace.delete();
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_sample(input logic [N_IN-1:0] d, input int hold);
        exp_t e;
        int   t  = 0;
        int   mm = 0;
        int   idx = 0;
        e = model(d, 0);
        while (!bus.out_valid && t < 200) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = N_IN'($urandom);
            @(posedge clk); #1;
            t++;
        end
        bus.in_valid = 1'b0;
        chk("out_valid_timeout", 64'(t >= 200), 64'd0);
        chk("rd_en_cycles", 64'(trace.size()), 64'(N_OUT*(N_IN+1)));
        for (int j = 0; j < N_OUT; j++) begin
            for (int k = 0; k <= N_IN; k++) begin
                int a;
                a = (k == N_IN) ? N_OUT*N_IN + j : j*N_IN + k;
                if (idx >= trace.size() || int'(trace[idx]) != a) mm++;
                idx++;
            end
        end
        chk("addr_trace_errs", 64'(mm), 64'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = N_IN'($urandom);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_out_d", 64'(bus.out_d), 64'(e.d));
            chk("hold_out_sum", 64'(bus.out_sum), 64'(e.sum));
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", 64'(bus.out_valid), 64'd0);
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
    endtask

    task automatic send(input logic [N_IN-1:0] d, input int hold);
        accept_sample(d);
        finish_sample(d, hold);
    endtask

    task automatic set_mem(input logic [WW-1:0] w, input logic [WW-1:0] b0,
                           input logic [WW-1:0] b1, input logic [WW-1:0] b2,
                           input logic [WW-1:0] b3);
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        for (int i = 0; i < N_OUT*N_IN; i++) mem[i] = w;
        mem[64] = b0;
        mem[65] = b1;
        mem[66] = b2;
        mem[67] = b3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_IN-1:0] d;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        set_mem('0, '0, '0, '0, '0);
        #1 reset = 1'b1;
        #2;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_wb_rd_en", 64'(bus.wb_rd_en), 64'd0);
        chk("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
        chk("rst_out_d", 64'(bus.out_d), 64'd0);
        chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // zero bank
        send(16'hFFFF, 2);
        // all weights -1, zero biases
        set_mem(10'h3FF, '0, '0, '0, '0);
        send(16'hFFFF, 1);
        send(16'h0000, 0);
        // biases only
        set_mem('0, 10'd5, 10'h3FF, 10'd0, 10'h200);
        send(16'hA5A5, 1);
        chk("bias_pattern_out_d", 64'(model(16'hA5A5, 0).d), 64'b1010);

        // long hold with ignored in_valid
        for (int i = 0; i < 68; i++) mem[i] = WW'($urandom);
        send(N_IN'($urandom), 10);

        // reset mid-RUN, then same sample from clean state
        d = N_IN'($urandom);
        accept_sample(d);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrun_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrun_rst_wb_rd_en", 64'(bus.wb_rd_en), 64'd0);
        chk("midrun_rst_wb_addr", 64'(bus.wb_addr), 64'd0);
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send(d, 1);

        // random banks and samples
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 68; i++) mem[i] = WW'($urandom);
            send(N_IN'($urandom), $urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nn_layer_sequencer.md
NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 SHALL have parameter N_IN, default 16, meaning the number of binary inputs per sample.
REQ-002 SHALL have parameter N_OUT, default 4, meaning the number of neurons, i.e. output decision bits.
REQ-003 SHALL have parameter WW, default 10, meaning the weight/bias width in bits, two's complement.
REQ-004 SHALL have parameter AW, default 7, meaning the weight-bank address width (68 entries used).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_data, input, N_IN bits: binary input vector.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-010 SHALL have port wb_addr, output, AW bits: weight-bank read address.
REQ-011 SHALL have port wb_rd_en, output, 1 bit: weight-bank read strobe.
REQ-012 SHALL have port wb_data, input, WW bits: weight-bank read data, valid one cycle after the address is sampled.
REQ-013 SHALL have port out_d, output, N_OUT bits: activation decisions; bit N_OUT-1 is neuron 0.
REQ-014 SHALL have port out_sum, output, N_OUT*15 bits: signed pre-activation sums, packed like out_d.
REQ-015 SHALL have port out_valid, output, 1 bit: out_d/out_sum are valid.
REQ-016 SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-017 SHALL use FSM states IDLE, RUN, DRAIN, HOLD.
REQ-018 SHALL drive in_ready=1 only in IDLE; a sample is accepted on a rising edge with in_valid && in_ready, in_data is registered, and the state moves to RUN with address counter cnt=0.
REQ-019 SHALL, in RUN, drive wb_rd_en=1 and step cnt by 1 per cycle through 0..N_OUT*(N_IN+1)-1 (0..67); in all other states wb_rd_en=0.
REQ-020 SHALL issue the address sequence for neuron j (j=0..N_OUT-1) as j*N_IN+k for k=0..N_IN-1, then bias address N_OUT*N_IN+j: 0..15, 64, 16..31, 65, 32..47, 66, 48..63, 67.
REQ-021 SHALL pair weight index k of each neuron with input bit in_data[N_IN-1-k]; a weight is added when that bit is 1 and skipped (adds 0) when it is 0; the bias is always added.
REQ-022 SHALL sign-extend wb_data to a 15-bit signed accumulator; no overflow is possible (17 x 512 < 2^14), so no saturation is applied.
REQ-023 SHALL clear the accumulator at the first weight of each neuron, so neurons never share partial sums.
REQ-024 SHALL, when a neuron's bias data is accumulated, store the 15-bit sum in that neuron's out_sum field and set its out_d bit to 1 if sum >= 0, else 0.
REQ-025 SHALL enter DRAIN after the last address, wait one cycle for the final read data, then enter HOLD with out_valid=1.
REQ-026 SHALL assert out_valid exactly 69 rising edges after the acceptance edge (68 addresses + 1 read latency).
REQ-027 SHALL, in HOLD, keep out_d/out_sum stable while out_ready=0; on out_valid && out_ready it SHALL deassert out_valid and return to IDLE, with in_ready=1 on the following cycle (no overlap of samples).
REQ-028 SHALL ignore in_valid outside IDLE; in_data changes during RUN SHALL NOT affect the result.

Reset
REQ-029 SHALL, while reset=1, immediately force state=IDLE, cnt=0, accumulator=0, out_d=0, out_sum=0, out_valid=0, wb_rd_en=0, wb_addr=0, and in_ready=1.
REQ-030 SHALL, on reset asserted mid-RUN/DRAIN/HOLD, abort the sample and discard partial sums; the first sample after reset release SHALL be processed from address 0.

Verification
REQ-031 SHALL pass: all weights and biases 0, in_data=16'hFFFF -> out_d=4'b1111, all sums 0, out_valid 69 edges after acceptance.
REQ-032 SHALL pass: all weights 10'h3FF (-1), biases 0, in_data=16'hFFFF -> each sum -16, out_d=4'b0000; with in_data=16'h0000 -> sums 0, out_d=4'b1111.
REQ-033 SHALL pass: weights 0, biases {+5,-1,0,-512} at 64..67 -> out_sum fields {5,-1,0,-512}, out_d=4'b1010.
REQ-034 SHALL pass: wb_addr trace during RUN equals the 68-entry sequence of REQ-020 exactly, with wb_rd_en high for exactly 68 cycles.
REQ-035 SHALL pass: out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> out_valid drops, and in_ready=1 on the next cycle.
REQ-036 SHALL pass: reset pulsed 30 cycles into RUN -> out_valid=0, in_ready=1, wb_rd_en=0 immediately; the next sample gives the same result as from a clean start.
